// File: rtl/id_ex_stage_reg_if.sv
// ID->EX boundary bundle: decode-stage inputs, registered EX-stage copies,
// and the load-use stall / bubble count returned to the front end.
interface id_ex_stage_reg_if #(parameter int CNT_W = 32);
  logic             stall_in_IDEX;
  logic             flush_in_IDEX;
  logic             valid_in_IDEX;
  logic [31:0]      PC_in_IDEX;
  logic [31:0]      Inst_in_IDEX;
  logic [31:0]      Rs1_in_IDEX;
  logic [31:0]      Rs2_in_IDEX;
  logic [31:0]      Imm_in_IDEX;
  logic [4:0]       Rd_addr_in_IDEX;
  logic             ALUSrc_B_in_IDEX;
  logic [3:0]       ALU_control_in_IDEX;
  logic             Branch_in_IDEX;
  logic             BranchN_in_IDEX;
  logic             MemRW_in_IDEX;
  logic [1:0]       Jump_in_IDEX;
  logic [1:0]       MemtoReg_in_IDEX;
  logic             RegWrite_in_IDEX;

  logic             valid_out_IDEX;
  logic [31:0]      PC_out_IDEX;
  logic [31:0]      Inst_out_IDEX;
  logic [31:0]      Rs1_out_IDEX;
  logic [31:0]      Rs2_out_IDEX;
  logic [31:0]      Imm_out_IDEX;
  logic [4:0]       Rd_addr_out_IDEX;
  logic [4:0]       Rs1_addr_out_IDEX;
  logic [4:0]       Rs2_addr_out_IDEX;
  logic             ALUSrc_B_out_IDEX;
  logic [3:0]       ALU_control_out_IDEX;
  logic             Branch_out_IDEX;
  logic             BranchN_out_IDEX;
  logic             MemRW_out_IDEX;
  logic [1:0]       Jump_out_IDEX;
  logic [1:0]       MemtoReg_out_IDEX;
  logic             RegWrite_out_IDEX;
  logic             hazard_stall_IDEX;
  logic [CNT_W-1:0] bubble_cnt_IDEX;

  modport master (
    output stall_in_IDEX, flush_in_IDEX, valid_in_IDEX, PC_in_IDEX, Inst_in_IDEX,
           Rs1_in_IDEX, Rs2_in_IDEX, Imm_in_IDEX, Rd_addr_in_IDEX, ALUSrc_B_in_IDEX,
           ALU_control_in_IDEX, Branch_in_IDEX, BranchN_in_IDEX, MemRW_in_IDEX,
           Jump_in_IDEX, MemtoReg_in_IDEX, RegWrite_in_IDEX,
    input  valid_out_IDEX, PC_out_IDEX, Inst_out_IDEX, Rs1_out_IDEX, Rs2_out_IDEX,
           Imm_out_IDEX, Rd_addr_out_IDEX, Rs1_addr_out_IDEX, Rs2_addr_out_IDEX,
           ALUSrc_B_out_IDEX, ALU_control_out_IDEX, Branch_out_IDEX, BranchN_out_IDEX,
           MemRW_out_IDEX, Jump_out_IDEX, MemtoReg_out_IDEX, RegWrite_out_IDEX,
           hazard_stall_IDEX, bubble_cnt_IDEX
  );

  modport slave (
    input  stall_in_IDEX, flush_in_IDEX, valid_in_IDEX, PC_in_IDEX, Inst_in_IDEX,
           Rs1_in_IDEX, Rs2_in_IDEX, Imm_in_IDEX, Rd_addr_in_IDEX, ALUSrc_B_in_IDEX,
           ALU_control_in_IDEX, Branch_in_IDEX, BranchN_in_IDEX, MemRW_in_IDEX,
           Jump_in_IDEX, MemtoReg_in_IDEX, RegWrite_in_IDEX,
    output valid_out_IDEX, PC_out_IDEX, Inst_out_IDEX, Rs1_out_IDEX, Rs2_out_IDEX,
           Imm_out_IDEX, Rd_addr_out_IDEX, Rs1_addr_out_IDEX, Rs2_addr_out_IDEX,
           ALUSrc_B_out_IDEX, ALU_control_out_IDEX, Branch_out_IDEX, BranchN_out_IDEX,
           MemRW_out_IDEX, Jump_out_IDEX, MemtoReg_out_IDEX, RegWrite_out_IDEX,
           hazard_stall_IDEX, bubble_cnt_IDEX
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with load-use bubble insertion, external hold,
// redirect flush and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
  parameter int CNT_W = 32
) (
  input logic               clk_IDEX,
  input logic               rst_IDEX,
  id_ex_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        alusrc_b;
    logic [3:0]  alu_ctrl;
    logic        branch;
    logic        branchn;
    logic        memrw;
    logic [1:0]  jump;
    logic [1:0]  memtoreg;
    logic        regwrite;
  } idex_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  idex_t            r_ex_p0;
  idex_t            w_load;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [4:0]       w_op;
  logic             w_load_ex;
  logic             w_use_rs1;
  logic             w_use_rs2;
  logic             w_hazard;

  always_comb begin
    w_load          = '0;
    w_load.valid    = 1'b1;
    w_load.pc       = bus.PC_in_IDEX;
    w_load.inst     = bus.Inst_in_IDEX;
    w_load.rs1      = bus.Rs1_in_IDEX;
    w_load.rs2      = bus.Rs2_in_IDEX;
    w_load.imm      = bus.Imm_in_IDEX;
    w_load.rd       = bus.Rd_addr_in_IDEX;
    w_load.rs1_addr = bus.Inst_in_IDEX[19:15];
    w_load.rs2_addr = bus.Inst_in_IDEX[24:20];
    w_load.alusrc_b = bus.ALUSrc_B_in_IDEX;
    w_load.alu_ctrl = bus.ALU_control_in_IDEX;
    w_load.branch   = bus.Branch_in_IDEX;
    w_load.branchn  = bus.BranchN_in_IDEX;
    w_load.memrw    = bus.MemRW_in_IDEX;
    w_load.jump     = bus.Jump_in_IDEX;
    w_load.memtoreg = bus.MemtoReg_in_IDEX;
    w_load.regwrite = bus.RegWrite_in_IDEX;
  end

  // Load-use detection: a valid load in EX writing a nonzero rd that the ID
  // instruction actually reads (LUI/AUIPC/JAL have no rs1; only R/S/B read rs2).
  assign w_op      = bus.Inst_in_IDEX[6:2];
  assign w_load_ex = r_ex_p0.valid & r_ex_p0.regwrite &
                     (r_ex_p0.memtoreg == 2'b01) & (r_ex_p0.rd != 5'd0);
  assign w_use_rs1 = !(w_op inside {5'b01101, 5'b00101, 5'b11011});
  assign w_use_rs2 = w_op inside {5'b01100, 5'b01000, 5'b11000};
  assign w_hazard  = bus.valid_in_IDEX & w_load_ex &
                     ((w_use_rs1 & (bus.Inst_in_IDEX[19:15] == r_ex_p0.rd)) |
                      (w_use_rs2 & (bus.Inst_in_IDEX[24:20] == r_ex_p0.rd)));

  assign bus.hazard_stall_IDEX = w_hazard & ~bus.flush_in_IDEX & ~bus.stall_in_IDEX;

  // ID -> EX boundary
  always_ff @(posedge clk_IDEX) begin
    if (rst_IDEX) begin
      r_ex_p0      <= '0;
      r_bubble_cnt <= '0;
    end else if (bus.flush_in_IDEX) begin
      r_ex_p0 <= '0;
    end else if (bus.stall_in_IDEX) begin
      r_ex_p0 <= r_ex_p0;
    end else if (w_hazard) begin
      r_ex_p0      <= '0;
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end else if (bus.valid_in_IDEX) begin
      r_ex_p0 <= w_load;
    end else begin
      r_ex_p0 <= '0;
    end
  end

  assign bus.valid_out_IDEX       = r_ex_p0.valid;
  assign bus.PC_out_IDEX          = r_ex_p0.pc;
  assign bus.Inst_out_IDEX        = r_ex_p0.inst;
  assign bus.Rs1_out_IDEX         = r_ex_p0.rs1;
  assign bus.Rs2_out_IDEX         = r_ex_p0.rs2;
  assign bus.Imm_out_IDEX         = r_ex_p0.imm;
  assign bus.Rd_addr_out_IDEX     = r_ex_p0.rd;
  assign bus.Rs1_addr_out_IDEX    = r_ex_p0.rs1_addr;
  assign bus.Rs2_addr_out_IDEX    = r_ex_p0.rs2_addr;
  assign bus.ALUSrc_B_out_IDEX    = r_ex_p0.alusrc_b;
  assign bus.ALU_control_out_IDEX = r_ex_p0.alu_ctrl;
  assign bus.Branch_out_IDEX      = r_ex_p0.branch;
  assign bus.BranchN_out_IDEX     = r_ex_p0.branchn;
  assign bus.MemRW_out_IDEX       = r_ex_p0.memrw;
  assign bus.Jump_out_IDEX        = r_ex_p0.jump;
  assign bus.MemtoReg_out_IDEX    = r_ex_p0.memtoreg;
  assign bus.RegWrite_out_IDEX    = r_ex_p0.regwrite;
  assign bus.bubble_cnt_IDEX      = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed plus randomized checks of the ID->EX register against a
// rule-level model of load-use bubbling, hold, flush and bubble counting.
module tb_id_ex_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.CNT_W(32)) ifc ();

  id_ex_stage_reg #(.CNT_W(32)) dut (
    .clk_IDEX (clk),
    .rst_IDEX (rst),
    .bus      (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: architectural contents of the EX stage
  logic        m_valid;
  logic [31:0] m_pc, m_inst, m_rs1, m_rs2, m_imm, m_cnt;
  logic [4:0]  m_rd;
  logic        m_alusrc, m_br, m_brn, m_mem, m_rw;
  logic [3:0]  m_alu;
  logic [1:0]  m_jump, m_mtr;

  localparam logic [31:0] ADD_X3 = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] LW_X5  = 32'h0002A283;  // lw  x5,0(x5)
  localparam logic [31:0] ADD_X6 = 32'h00128333;  // add x6,x5,x1
  localparam logic [31:0] LW_X0  = 32'h00002003;  // lw  x0,0(x0)
  localparam logic [31:0] ADD_X0 = 32'h00100333;  // add x6,x0,x1
  localparam logic [31:0] LUI_X5 = 32'h000282B7;  // lui x5 with inst[19:15]=5

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_valid = 0; m_pc = 0; m_inst = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
    m_alusrc = 0; m_br = 0; m_brn = 0; m_mem = 0; m_rw = 0; m_alu = 0; m_jump = 0; m_mtr = 0;
  endtask

  function automatic bit model_hazard();
    bit          ld_in_ex;
    logic [6:0]  opc;
    bit          reads1, reads2;
    ld_in_ex = m_valid && m_rw && (m_mtr == 2'b01) && (m_rd != 0);
    opc      = ifc.Inst_in_IDEX[6:0];
    reads1   = !(opc inside {7'b0110111, 7'b0010111, 7'b1101111});
    reads2   = opc inside {7'b0110011, 7'b0100011, 7'b1100011};
    return ifc.valid_in_IDEX && ld_in_ex &&
           ((reads1 && ifc.Inst_in_IDEX[19:15] == m_rd) ||
            (reads2 && ifc.Inst_in_IDEX[24:20] == m_rd));
  endfunction

  task automatic model_edge();
    bit hz;
    hz = model_hazard();
    if (rst) begin
      model_bubble();
      m_cnt = 0;
    end else if (ifc.flush_in_IDEX) begin
      model_bubble();
    end else if (ifc.stall_in_IDEX) begin
      // EX keeps its instruction
    end else if (hz) begin
      model_bubble();
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else if (ifc.valid_in_IDEX) begin
      m_valid = 1;               m_pc   = ifc.PC_in_IDEX;
      m_inst  = ifc.Inst_in_IDEX; m_rs1 = ifc.Rs1_in_IDEX;
      m_rs2   = ifc.Rs2_in_IDEX;  m_imm = ifc.Imm_in_IDEX;
      m_rd    = ifc.Rd_addr_in_IDEX;
      m_alusrc = ifc.ALUSrc_B_in_IDEX; m_alu = ifc.ALU_control_in_IDEX;
      m_br  = ifc.Branch_in_IDEX;  m_brn = ifc.BranchN_in_IDEX;
      m_mem = ifc.MemRW_in_IDEX;   m_jump = ifc.Jump_in_IDEX;
      m_mtr = ifc.MemtoReg_in_IDEX; m_rw = ifc.RegWrite_in_IDEX;
    end else begin
      model_bubble();
    end
  endtask

  task automatic check_all();
    chk("valid_out", ifc.valid_out_IDEX, m_valid);
    chk("PC_out", ifc.PC_out_IDEX, m_pc);
    chk("Inst_out", ifc.Inst_out_IDEX, m_inst);
    chk("Rs1_out", ifc.Rs1_out_IDEX, m_rs1);
    chk("Rs2_out", ifc.Rs2_out_IDEX, m_rs2);
    chk("Imm_out", ifc.Imm_out_IDEX, m_imm);
    chk("Rd_addr_out", ifc.Rd_addr_out_IDEX, m_rd);
    chk("Rs1_addr_out", ifc.Rs1_addr_out_IDEX, m_inst[19:15]);
    chk("Rs2_addr_out", ifc.Rs2_addr_out_IDEX, m_inst[24:20]);
    chk("ctrl_out",
        {ifc.ALUSrc_B_out_IDEX, ifc.ALU_control_out_IDEX, ifc.Branch_out_IDEX,
         ifc.BranchN_out_IDEX, ifc.MemRW_out_IDEX, ifc.Jump_out_IDEX,
         ifc.MemtoReg_out_IDEX, ifc.RegWrite_out_IDEX},
        {m_alusrc, m_alu, m_br, m_brn, m_mem, m_jump, m_mtr, m_rw});
    chk("bubble_cnt", ifc.bubble_cnt_IDEX, m_cnt);
  endtask

  // Inputs are applied at the falling edge; the stall flag is checked just
  // after, and registered outputs at the next falling edge.
  task automatic step();
    #1;
    if (!rst)
      chk("hazard_stall", ifc.hazard_stall_IDEX,
          model_hazard() && !ifc.flush_in_IDEX && !ifc.stall_in_IDEX);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic ctl(input bit r, input bit st, input bit fl);
    rst = r; ifc.stall_in_IDEX = st; ifc.flush_in_IDEX = fl;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [4:0] rd, input bit rw, input logic [1:0] mtr);
    ifc.valid_in_IDEX       = v;
    ifc.PC_in_IDEX          = pc;
    ifc.Inst_in_IDEX        = inst;
    ifc.Rs1_in_IDEX         = pc + 32'h100;
    ifc.Rs2_in_IDEX         = pc + 32'h200;
    ifc.Imm_in_IDEX         = inst ^ 32'hA5A5_0F0F;
    ifc.Rd_addr_in_IDEX     = rd;
    ifc.ALUSrc_B_in_IDEX    = pc[7];
    ifc.ALU_control_in_IDEX = pc[11:8];
    ifc.Branch_in_IDEX      = pc[2];
    ifc.BranchN_in_IDEX     = pc[3];
    ifc.MemRW_in_IDEX       = pc[4];
    ifc.Jump_in_IDEX        = pc[6:5];
    ifc.MemtoReg_in_IDEX    = mtr;
    ifc.RegWrite_in_IDEX    = rw;
    ctl(0, 0, 0);
  endtask

  task automatic drive_rand();
    logic [6:0]  ops [9] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b0010011, 7'b1100111};
    logic [31:0] inst;
    inst        = $urandom();
    inst[6:0]   = ops[$urandom_range(0, 8)];
    inst[19:15] = 5'($urandom_range(0, 3));
    inst[24:20] = 5'($urandom_range(0, 3));
    drive(($urandom_range(0, 7) != 0), $urandom(), inst, 5'($urandom_range(0, 3)),
          1'($urandom()), 2'($urandom()));
    ifc.Rs1_in_IDEX         = $urandom();
    ifc.Rs2_in_IDEX         = $urandom();
    ifc.ALU_control_in_IDEX = 4'($urandom());
  endtask

  initial begin
    model_bubble();
    m_cnt = 0;
    drive(0, 0, 0, 0, 0, 0);

    // Reset held for two cycles
    ctl(1, 0, 0); step();
    ctl(1, 0, 0); step();
    chk("reset_valid", ifc.valid_out_IDEX, 0);
    chk("reset_cnt", ifc.bubble_cnt_IDEX, 0);
    chk("reset_pc", ifc.PC_out_IDEX, 0);

    // Pass-through
    drive(1, 32'h10, ADD_X3, 3, 1, 2'b00); step();
    chk("pass_rd", ifc.Rd_addr_out_IDEX, 3);
    chk("pass_regwrite", ifc.RegWrite_out_IDEX, 1);
    chk("pass_pc", ifc.PC_out_IDEX, 32'h10);
    chk("pass_valid", ifc.valid_out_IDEX, 1);

    // Load-use: one bubble, then the held ADD loads
    drive(1, 32'h14, LW_X5, 5, 1, 2'b01); step();
    drive(1, 32'h18, ADD_X6, 6, 1, 2'b00);
    #1 chk("lu_hazard", ifc.hazard_stall_IDEX, 1);
    step();
    chk("lu_bubble_valid", ifc.valid_out_IDEX, 0);
    chk("lu_cnt", ifc.bubble_cnt_IDEX, 1);
    #1 chk("lu_hazard_clear", ifc.hazard_stall_IDEX, 0);
    step();
    chk("lu_add_rd", ifc.Rd_addr_out_IDEX, 6);

    // No false hazard: load to x0, and LUI after a load
    drive(1, 32'h1C, LW_X0, 0, 1, 2'b01); step();
    drive(1, 32'h20, ADD_X0, 6, 1, 2'b00); step();
    chk("x0_no_bubble", ifc.valid_out_IDEX, 1);
    drive(1, 32'h24, LW_X5, 5, 1, 2'b01); step();
    drive(1, 32'h28, LUI_X5, 5, 1, 2'b00); step();
    chk("lui_no_bubble", ifc.valid_out_IDEX, 1);
    chk("nofalse_cnt", ifc.bubble_cnt_IDEX, 1);

    // Flush + stall + hazard together
    drive(1, 32'h2C, LW_X5, 5, 1, 2'b01); step();
    drive(1, 32'h30, ADD_X6, 6, 1, 2'b00); ctl(0, 1, 1);
    #1 chk("fsh_hazard", ifc.hazard_stall_IDEX, 0);
    step();
    chk("fsh_valid", ifc.valid_out_IDEX, 0);
    chk("fsh_cnt", ifc.bubble_cnt_IDEX, 1);

    // External hold for three cycles
    drive(1, 32'h40, ADD_X3, 3, 1, 2'b00); step();
    for (int i = 0; i < 3; i++) begin
      drive_rand(); ctl(0, 1, 0); step();
      chk("hold_pc", ifc.PC_out_IDEX, 32'h40);
    end

    // Counter saturation
    force dut.r_bubble_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_bubble_cnt;
    m_cnt = 32'hFFFF_FFFF;
    drive(1, 32'h50, LW_X5, 5, 1, 2'b01); step();
    drive(1, 32'h54, ADD_X6, 6, 1, 2'b00); step();
    chk("sat_valid", ifc.valid_out_IDEX, 0);
    chk("sat_cnt", ifc.bubble_cnt_IDEX, 32'hFFFF_FFFF);

    // Reset during a load-use stall
    drive(1, 32'h60, LW_X5, 5, 1, 2'b01); step();
    drive(1, 32'h64, ADD_X6, 6, 1, 2'b00); ctl(1, 0, 0); step();
    ctl(0, 0, 0);
    #1 chk("rst_hazard_drop", ifc.hazard_stall_IDEX, 0);
    chk("rst_cnt", ifc.bubble_cnt_IDEX, 0);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      ctl(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
